// File: rtl/seg_scan_decoder.sv
// Passive monitor for a multiplexed 4-digit common-anode 7-segment bus; rebuilds the displayed 16-bit value.
// Optional build macro SEG_DP_CAPTURE_EN: capture per-digit decimal points into O_dp (otherwise O_dp is 0).
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 20000
) (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    input  logic [3:0]  I_sel,
    input  logic [7:0]  I_seg,
    output logic [15:0] O_data,
    output logic        O_valid,
    output logic [3:0]  O_dp,
    output logic        O_err,
    output logic        O_timeout
);

    localparam int unsigned DIGITS = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 8;
    localparam int unsigned DATA_W = DIGITS * NIB_W;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDLE_W = 16;

    localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(TIMEOUT);

    // Inverse hex-to-segment lookup on seg[6:0]; bit 4 flags a legal pattern.
    function automatic logic [NIB_W:0] seg_decode(input logic [6:0] s);
        logic [NIB_W:0] r;
        r = '0;
        case (s)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [DIGITS-1:0] sel_s1, sel_s2;
    logic [SEG_W-1:0]  seg_s1, seg_s2;
    logic [CNT_W-1:0]  stable_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [DIGITS-1:0] mask, mask_nxt;
    logic [DATA_W-1:0] shadow, shadow_nxt;

    logic              changed_c;
    logic              sample_c;
    logic              sel_blank_c;
    logic              sel_onehot_c;
    logic [NIB_W:0]    dec_c;
    logic              dec_hit_c;
    logic [NIB_W-1:0]  dec_nib_c;
    logic              digit_wr_c;
    logic              err_set_c;
    logic              frame_done_c;
    logic              idle_hit_c;

    // Two-flop synchronizers on the asynchronous display pins.
    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            sel_s1 <= '0;
            sel_s2 <= '0;
            seg_s1 <= '0;
            seg_s2 <= '0;
        end else begin
            sel_s1 <= I_sel;
            sel_s2 <= sel_s1;
            seg_s1 <= I_seg;
            seg_s2 <= seg_s1;
        end
    end

    // The first stage is next cycle's second-stage value, so no extra history flop is needed.
    assign changed_c = ({sel_s1, seg_s1} != {sel_s2, seg_s2});
    assign sample_c  = !changed_c && (stable_cnt == (STABLE_MAX - CNT_W'(1)));

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            stable_cnt <= '0;
        end else if (changed_c) begin
            stable_cnt <= '0;
        end else if (stable_cnt != STABLE_MAX) begin
            stable_cnt <= stable_cnt + CNT_W'(1);
        end
    end

    assign sel_blank_c  = (sel_s2 == '0);
    assign sel_onehot_c = !sel_blank_c && ((sel_s2 & (sel_s2 - DIGITS'(1))) == '0);
    assign dec_c        = seg_decode(seg_s2[6:0]);
    assign dec_hit_c    = dec_c[NIB_W];
    assign dec_nib_c    = dec_c[NIB_W-1:0];

    assign digit_wr_c   = sample_c && sel_onehot_c && dec_hit_c;
    assign err_set_c    = sample_c && ((!sel_blank_c && !sel_onehot_c) || (sel_onehot_c && !dec_hit_c));
    assign frame_done_c = (mask == '1);
    assign idle_hit_c   = !sample_c && (idle_cnt == (IDLE_MAX - IDLE_W'(1)));

    // Shadow/mask update: clears from frame completion or timeout happen before a same-cycle digit write.
    always_comb begin
        mask_nxt   = mask;
        shadow_nxt = shadow;
        if (frame_done_c || idle_hit_c) begin
            mask_nxt = '0;
        end
        if (digit_wr_c) begin
            mask_nxt = mask_nxt | sel_s2;
            for (int i = 0; i < DIGITS; i++) begin
                if (sel_s2[i]) begin
                    shadow_nxt[NIB_W*i +: NIB_W] = dec_nib_c;
                end
            end
        end
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            mask   <= '0;
            shadow <= '0;
        end else begin
            mask   <= mask_nxt;
            shadow <= shadow_nxt;
        end
    end

    // Idle watchdog; a sample event always beats a coincident timeout.
    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            idle_cnt  <= '0;
            O_timeout <= 1'b0;
        end else if (sample_c) begin
            idle_cnt  <= '0;
            O_timeout <= 1'b0;
        end else begin
            if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
            if (idle_hit_c) begin
                O_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            O_data  <= '0;
            O_valid <= 1'b0;
            O_err   <= 1'b0;
        end else begin
            O_valid <= frame_done_c;
            if (frame_done_c) begin
                O_data <= shadow;
            end
            if (err_set_c) begin
                O_err <= 1'b1;
            end
        end
    end

`ifdef SEG_DP_CAPTURE_EN
    logic [DIGITS-1:0] shadow_dp, shadow_dp_nxt;

    // Decimal point is active-low on the bus; stored as 1 = lit.
    always_comb begin
        shadow_dp_nxt = shadow_dp;
        if (digit_wr_c) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sel_s2[i]) begin
                    shadow_dp_nxt[i] = ~seg_s2[SEG_W-1];
                end
            end
        end
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            shadow_dp <= '0;
            O_dp      <= '0;
        end else begin
            shadow_dp <= shadow_dp_nxt;
            if (frame_done_c) begin
                O_dp <= shadow_dp;
            end
        end
    end
`else
    assign O_dp = 4'b0000;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: table-driven frames, scoreboard of expected frames, corner sequences.
module tb_seg_scan_decoder;

    localparam int unsigned STABLE = 4;
    localparam int unsigned TMO    = 300;
    localparam int unsigned HOLD   = 10;

`ifdef SEG_DP_CAPTURE_EN
    localparam logic [3:0] DP_MASK = 4'b1111;
`else
    localparam logic [3:0] DP_MASK = 4'b0000;
`endif

    logic        I_sys_clk = 1'b0;
    logic        I_rst;
    logic [3:0]  I_sel;
    logic [7:0]  I_seg;
    logic [15:0] O_data;
    logic        O_valid;
    logic [3:0]  O_dp;
    logic        O_err;
    logic        O_timeout;

    seg_scan_decoder #(
        .STABLE_CYCLES(STABLE),
        .TIMEOUT      (TMO)
    ) dut (
        .I_sys_clk(I_sys_clk),
        .I_rst    (I_rst),
        .I_sel    (I_sel),
        .I_seg    (I_seg),
        .O_data   (O_data),
        .O_valid  (O_valid),
        .O_dp     (O_dp),
        .O_err    (O_err),
        .O_timeout(O_timeout)
    );

    always #5 I_sys_clk = ~I_sys_clk;

    typedef struct {
        logic [3:0][7:0] seg;
        logic [15:0]     data;
        logic [3:0]      dp;
    } frame_vec_t;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
    } frame_exp_t;

    frame_vec_t vecs[7];
    frame_exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; outputs sampled on the falling edge, where any O_valid pulse is scored.
    task automatic tick();
        frame_exp_t e;
        @(negedge I_sys_clk);
        if (O_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: O_valid=1 data=0x%0h, expected no pulse at %0t", O_data, $time);
            end else begin
                e = sb_q.pop_front();
                check("frame_data", 32'(O_data), 32'(e.data));
                check("frame_dp", 32'(O_dp), 32'(e.dp));
            end
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [7:0] seg, input int n);
        I_sel = sel;
        I_seg = seg;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic drive_digit(input int d, input logic [7:0] seg);
        drive(4'(1 << d), seg, HOLD);
    endtask

    task automatic expect_frame(input logic [15:0] d, input logic [3:0] dp);
        frame_exp_t e;
        e.data = d;
        e.dp   = dp & DP_MASK;
        sb_q.push_back(e);
    endtask

    task automatic send_frame(input frame_vec_t v);
        expect_frame(v.data, v.dp);
        for (int d = 0; d < 4; d++) drive_digit(d, v.seg[d]);
        check("frame_consumed", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, 32'(O_data), 32'd0);
        check({tag, "_valid"}, 32'(O_valid), 32'd0);
        check({tag, "_dp"}, 32'(O_dp), 32'd0);
        check({tag, "_err"}, 32'(O_err), 32'd0);
        check({tag, "_timeout"}, 32'(O_timeout), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        vecs[0] = '{32'hB0F9A4C0, 16'h3120, 4'b0000};
        vecs[1] = '{32'hA1C68388, 16'hDCBA, 4'b0000};
        vecs[2] = '{32'hA1C68388, 16'hDCBA, 4'b0000};
        vecs[3] = '{32'hA1C68388, 16'hDCBA, 4'b0000};
        vecs[4] = '{32'h8E409092, 16'hF095, 4'b0100};
        vecs[5] = '{32'h40F9A419, 16'h0124, 4'b1001};
        vecs[6] = '{32'h828680F8, 16'h6E87, 4'b0000};

        I_rst = 1'b1;
        I_sel = 4'b0000;
        I_seg = 8'hFF;
        for (int k = 0; k < 3; k++) tick();
        check_idle_outputs("reset");
        I_rst = 1'b0;
        drive(4'b0000, 8'hFF, 6);
        check_idle_outputs("post_reset");

        // Table of full frames.
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i]);
            check("table_err", 32'(O_err), 32'd0);
            check("table_timeout", 32'(O_timeout), 32'd0);
        end

        // Glitches shorter than the stability window must never sample.
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < 4; d++) drive(4'(1 << d), vecs[5].seg[d], STABLE - 1);
        drive(4'b0000, 8'hFF, HOLD);
        check("glitch_err", 32'(O_err), 32'd0);
        check("glitch_data_hold", 32'(O_data), 32'h6E87);

        // Undecodable pattern: error set, digit left unmarked.
        drive_digit(0, 8'hFF);
        check("bad_seg_err", 32'(O_err), 32'd1);
        for (int d = 1; d < 4; d++) drive_digit(d, vecs[0].seg[d]);
        check("bad_seg_err_sticky", 32'(O_err), 32'd1);
        expect_frame(16'h312A, 4'b0000);
        drive_digit(0, vecs[1].seg[0]);
        check("bad_seg_completion", 32'(sb_q.size()), 32'd0);

        // Reset mid-frame discards partial digits 0,1; out-of-order frame completes on the fourth digit.
        drive_digit(0, vecs[5].seg[0]);
        drive_digit(1, vecs[5].seg[1]);
        I_rst = 1'b1;
        tick();
        check_idle_outputs("mid_reset");
        I_rst = 1'b0;
        expect_frame(16'hF095, 4'b0100);
        drive_digit(2, vecs[4].seg[2]);
        drive_digit(3, vecs[4].seg[3]);
        check("reset_partial_dropped", 32'(sb_q.size()), 32'd1);
        drive_digit(0, vecs[4].seg[0]);
        drive_digit(1, vecs[4].seg[1]);
        check("reset_reorder_done", 32'(sb_q.size()), 32'd0);
        send_frame(vecs[0]);
        check("after_reset_err", 32'(O_err), 32'd0);

        // Non-one-hot select flags an error without touching the data.
        drive(4'b0110, 8'hC0, HOLD);
        check("bad_sel_err", 32'(O_err), 32'd1);
        check("bad_sel_data", 32'(O_data), 32'h3120);

        // Timeout drops digits 0,1; the next sample clears the timeout.
        drive_digit(0, vecs[1].seg[0]);
        drive_digit(1, vecs[1].seg[1]);
        for (int k = 0; k < TMO - 20; k++) tick();
        check("timeout_early", 32'(O_timeout), 32'd0);
        waited = 0;
        while (O_timeout !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check("timeout_assert", 32'(O_timeout), 32'd1);
        drive_digit(2, vecs[0].seg[2]);
        check("timeout_clear", 32'(O_timeout), 32'd0);
        drive_digit(3, vecs[0].seg[3]);
        check("timeout_no_valid", 32'(sb_q.size()), 32'd0);
        expect_frame(16'h3187, 4'b0000);
        drive_digit(0, vecs[6].seg[0]);
        drive_digit(1, vecs[6].seg[1]);
        check("timeout_refill", 32'(sb_q.size()), 32'd0);
        send_frame(vecs[6]);
        send_frame(vecs[4]);

        drive(4'b0000, 8'hFF, HOLD);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
